// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller beside the MEM stage: decides flushes,
// holds SR/Cause/EPC/PRId and services mtc0/mfc0/eret.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID     = 32'h1234_5678,
    parameter logic [31:0] HANDLER  = 32'h0000_4180,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exccode_m,
    input  logic        eret_m,
    input  logic [5:0]  hwint,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc,
    output logic        exc_flush
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im_q,    sr_im_d;
    logic        sr_exl_q,   sr_exl_d;
    logic        sr_ie_q,    sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,      epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] fault_pc;

    assign sr_word    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
    assign cause_word = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};

    assign int_req   = valid_m & sr_ie_q & ~sr_exl_q & (|(cause_ip_q & sr_im_q));
    assign exc_req   = valid_m & ~sr_exl_q & (exccode_m != 5'd0);
    assign exc_flush = int_req | exc_req;

    // A fault in a delay slot restarts at the branch so the branch is re-executed.
    assign fault_pc = (bd_m ? (pc_m - 32'd4) : pc_m) & ~32'h3;

    assign epc_out    = epc_q;
    assign handler_pc = HANDLER;

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = sr_word;
            ADDR_CAUSE: cp0_rdata = cause_word;
            ADDR_EPC:   cp0_rdata = epc_q;
            ADDR_PRID:  cp0_rdata = PRID;
            default:    cp0_rdata = 32'h0;
        endcase
    end

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hwint;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (exc_flush) begin
            // The faulting instruction's own mtc0 is dropped.
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? 5'd0 : exccode_m;
            cause_bd_d  = bd_m;
            epc_d       = fault_pc;
        end else if (eret_m) begin
            sr_exl_d = 1'b0;
        end else if (cp0_we) begin
            if (cp0_addr == ADDR_SR) begin
                sr_im_d  = cp0_wdata[15:10];
                sr_exl_d = cp0_wdata[1];
                sr_ie_d  = cp0_wdata[0];
            end else if (cp0_addr == ADDR_EPC) begin
                epc_d = cp0_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_im_q     <= SR_RESET[15:10];
            sr_exl_q    <= SR_RESET[1];
            sr_ie_q     <= SR_RESET[0];
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'b0;
            cause_exc_q <= 5'b0;
            epc_q       <= 32'h0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule
